// File: rtl/quick_pair_queue_if.sv
// Pair-queue port bundle: push/pop controls, pair data and status flags.
// The queue drives the slave modport; the producer/consumer side uses master.
interface quick_pair_queue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
);
  logic              clr;
  logic              enq;
  logic              deq;
  logic              lifo;
  logic [DATA_W-1:0] data_lt_i;
  logic [DATA_W-1:0] data_rt_i;
  logic [DATA_W-1:0] data_lt_o;
  logic [DATA_W-1:0] data_rt_o;
  logic              valid_o;
  logic [CNT_W-1:0]  count_o;
  logic              full_o;
  logic              empty_o;
  logic              overflow_o;
  logic              underflow_o;
  logic              dropped_o;

  modport master (
    output clr, enq, deq, lifo, data_lt_i, data_rt_i,
    input  data_lt_o, data_rt_o, valid_o, count_o, full_o, empty_o,
           overflow_o, underflow_o, dropped_o
  );

  modport slave (
    input  clr, enq, deq, lifo, data_lt_i, data_rt_i,
    output data_lt_o, data_rt_o, valid_o, count_o, full_o, empty_o,
           overflow_o, underflow_o, dropped_o
  );
endinterface

// File: rtl/quick_pair_queue.sv
// Runtime FIFO/LIFO queue of (left, right) partition-bound pairs.
// Optional QQ_PAIR_FILTER_EN discards pushes whose left bound is not below the right bound.
module quick_pair_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input logic           clk,
  input logic           rst,
  quick_pair_queue_if.slave q
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PtrMax  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_lt [DEPTH];
  logic [DATA_W-1:0] mem_rt [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q;
  logic             full_q, empty_q;
  logic             ovf_q, unf_q, drop_q;

  logic             filt, enq_req, enq_ok, deq_ok;
  logic [PTR_W-1:0] top_idx, wr_idx, head_idx;

`ifdef QQ_PAIR_FILTER_EN
  assign filt = q.enq && (q.data_lt_i >= q.data_rt_i);
`else
  assign filt = 1'b0;
`endif

  assign enq_req = q.enq && !filt;
  assign deq_ok  = q.deq && !empty_q;
  // A full queue still takes a push when a pop frees the slot on the same edge.
  assign enq_ok  = enq_req && (!full_q || q.deq);

  always_comb begin
    top_idx  = PTR_W'(count_q - CNT_W'(1));
    head_idx = mode_q ? top_idx : rd_ptr_q;
    wr_idx   = wr_ptr_q;
    if (mode_q) begin
      // Simultaneous push/pop on the stack overwrites the top in place.
      wr_idx = deq_ok ? top_idx : PTR_W'(count_q);
    end
    count_d = count_q;
    if (enq_ok && !deq_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (deq_ok && !enq_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok && !q.clr) begin
      mem_lt[wr_idx] <= q.data_lt_i;
      mem_rt[wr_idx] <= q.data_rt_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      mode_q   <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else if (q.clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (!mode_q && deq_ok) begin
        rd_ptr_q <= (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (!mode_q && enq_ok) begin
        wr_ptr_q <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      // Mode changes only take effect once the queue is drained and idle.
      if (empty_q && !enq_ok) begin
        mode_q <= q.lifo;
      end
      count_q <= count_d;
      full_q  <= (count_d == CntFull);
      empty_q <= (count_d == '0);
      ovf_q   <= enq_req && full_q && !q.deq;
      unf_q   <= q.deq && empty_q;
      drop_q  <= filt;
    end
  end

  assign q.data_lt_o   = empty_q ? '0 : mem_lt[head_idx];
  assign q.data_rt_o   = empty_q ? '0 : mem_rt[head_idx];
  assign q.valid_o     = !empty_q;
  assign q.count_o     = count_q;
  assign q.full_o      = full_q;
  assign q.empty_o     = empty_q;
  assign q.overflow_o  = ovf_q;
  assign q.underflow_o = unf_q;
  assign q.dropped_o   = drop_q;
endmodule
